mem_bridge: RTL

//  Memory-side neighbour of the microcoded controller. It takes the controller's memory strobes
//  (memen, memwrite, memsel address, memout write data) and runs one blocking transaction per

---
 rtl/mem_bridge_pkg.sv | 25 ++
 rtl/mem_bridge_if.sv | 44 ++++
 rtl/mem_timeout_ctr.sv | 40 ++++
 rtl/mem_bridge.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// ----------------------------------------------------------------------------
// mem_bridge_pkg
// Shared definitions for the memory bridge: default widths, the FSM state
// encoding and a helper that sizes the REQ-phase timeout counter.
// Optional feature macro used by the bridge: MEM_BRIDGE_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package mem_bridge_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    // Transaction state; the encodings are shared with the board-level memory model
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width able to hold 0..timeout
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// ----------------------------------------------------------------------------
// mem_bridge_if
// External req/ack memory port.
//   ext_req   : request, held until ack
//   ext_we    : write enable, valid with ext_req
//   ext_addr  : access address
//   ext_wdata : write data
//   ext_rdata : read data, valid in the ack cycle
//   ext_ack   : single-cycle completion pulse
// Modports: master (bridge side), slave (memory side).
// ----------------------------------------------------------------------------
interface mem_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;

    modport master (
        output ext_req,
        output ext_we,
        output ext_addr,
        output ext_wdata,
        input  ext_rdata,
        input  ext_ack
    );

    modport slave (
        input  ext_req,
        input  ext_we,
        input  ext_addr,
        input  ext_wdata,
        output ext_rdata,
        output ext_ack
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// ----------------------------------------------------------------------------
// mem_timeout_ctr
// Counts cycles spent waiting for an external ack and flags expiry.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (held while not waiting)
//   i_en       : count enable
//   o_expired  : count has reached TIMEOUT-1
// Only instantiated when MEM_BRIDGE_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module mem_timeout_ctr
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned       CNT_W = timer_width(TIMEOUT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturating wait counter; holds at LAST so expiry stays asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_bridge.sv
// ----------------------------------------------------------------------------
// mem_bridge
// Turns the microcoded controller's memory strobes into one blocking req/ack
// transaction per access and stalls the controller until it completes.
//   clk, rst     : clock, asynchronous active-high reset
//   i_memen      : controller access request (level)
//   i_memwrite   : 1 = write, 0 = read
//   i_memsel     : access address
//   i_memout     : write data
//   o_memin      : read data back to the controller (registered)
//   o_stall      : hold the controller (combinational)
//   o_err        : sticky timeout flag
//   ext          : external memory port (mem_bridge_if.master)
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to abort a request that sees
// no ack within TIMEOUT cycles; otherwise REQ waits forever and o_err is 0.
// ----------------------------------------------------------------------------
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_memen,
    input  logic              i_memwrite,
    input  logic [ADDR_W-1:0] i_memsel,
    input  logic [DATA_W-1:0] i_memout,
    output logic [DATA_W-1:0] o_memin,
    output logic              o_stall,
    output logic              o_err,
    mem_bridge_if.master      ext
);

    state_e            r_state;
    logic [DATA_W-1:0] r_memin;
    logic              r_ext_req;
    logic              r_ext_we;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_wdata;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    // Timer is held clear outside REQ, so it starts from zero on every entry
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state != ST_REQ),
        .i_en      (r_state == ST_REQ),
        .o_expired (w_expired)
    );

    assign o_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
    assign o_err            = 1'b0;
`endif

    // Transaction FSM with registered external-port and read-data outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_memin     <= '0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_memen) begin
                        r_ext_addr  <= i_memsel;
                        r_ext_wdata <= i_memout;
                        r_ext_we    <= i_memwrite;
                        r_ext_req   <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack in the expiry cycle still completes normally
                    if (ext.ext_ack) begin
                        if (!r_ext_we) begin
                            r_memin <= ext.ext_rdata;
                        end
                        r_ext_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end
`ifdef MEM_BRIDGE_TIMEOUT_EN
                    else if (w_expired) begin
                        if (!r_ext_we) begin
                            r_memin <= '1;
                        end
                        r_err     <= 1'b1;
                        r_ext_req <= 1'b0;
                        r_state   <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    // memen still high here belongs to the access just finished
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ext_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall releases in DONE so the controller advances exactly once per access
    assign o_stall = i_memen & (r_state != ST_DONE);

    assign o_memin       = r_memin;
    assign ext.ext_req   = r_ext_req;
    assign ext.ext_we    = r_ext_we;
    assign ext.ext_addr  = r_ext_addr;
    assign ext.ext_wdata = r_ext_wdata;

endmodule
